aurora_link_monitor: RTL and testbench
======================================

Name: aurora_link_monitor

Overview:
- Watches Aurora link status after the reset sequencer finishes and requests a new reset when the link stays down, drops, or logs too many errors.
- Its reset_req output drives the reset sequencer's external reset input, closing the bring-up loop.
- Bounded retries, with a sticky failure flag for software.
- Runs in the init_clk domain; all status inputs arrive already synchronized to init_clk.

Parameters:
- NLANES, 4, number of lanes in lane_up
- UP_TIMEOUT, 100000000, cycles allowed from seq_done to channel_up (1 s @ 100 MHz)
- REQ_CYCLES, 100, reset_req assertion length in cycles
- WINDOW_CYCLES, 1000000, soft-error observation window
- SOFT_ERR_LIMIT, 16, soft errors within one window that trigger a reset
- STABLE_CYCLES, 10000000, continuous link-up time that clears retry_count
- MAX_RETRY, 8, resets issued before entering FAILED

Ports:
- init_clk  in  1  clock
- init_rst_n  in  1  asynchronous active-low reset
- seq_done  in  1  reset sequencer finished (level)
- channel_up  in  1  Aurora channel up
- lane_up  in  NLANES  per-lane up
- soft_err  in  1  one-cycle soft error pulse
- hard_err  in  1  one-cycle hard error pulse
- clr_fail  in  1  pulse: leave FAILED, clear retry_count
- reset_req  out  1  reset request to sequencer
- link_ok  out  1  channel_up and all lanes up while in LINK_UP
- failed  out  1  sticky, retry budget exhausted
- retry_count  out  8  resets issued since last stable period
- last_cause  out  2  0 none, 1 timeout, 2 link drop / hard_err, 3 soft-error limit
- soft_err_total  out  16  saturating soft error count

Behaviour:
- Reset values: all outputs 0; state WAIT_SEQ; all counters 0. Outputs are registered, so there is 1 cycle of latency from a state change.
- WAIT_SEQ: when seq_done=1, go to WAIT_UP and clear the timer.
- WAIT_UP:
  - When channel_up=1 and &lane_up=1, go to LINK_UP.
  - When the timer reaches UP_TIMEOUT-1, set cause=1 and go to REQ.
  - If seq_done falls, return to WAIT_SEQ with no request.
- LINK_UP:
  - link_ok=1.
  - hard_err=1, channel_up=0, or any lane_up=0 sets cause=2 and goes to REQ.
  - When the window soft count reaches SOFT_ERR_LIMIT, set cause=3 and go to REQ.
  - Cause priority when events coincide: 2 over 3. Exactly one request is issued.
- Soft-error window:
  - Free-running counter that restarts on entering LINK_UP.
  - At WINDOW_CYCLES-1 the window soft count clears. A soft_err in that same cycle counts in the new window.
- Stability: a stable counter increments in LINK_UP. When it reaches STABLE_CYCLES, retry_count clears (once per LINK_UP entry).
- REQ:
  - If retry_count == MAX_RETRY, go to FAILED and do not assert reset_req.
  - Otherwise increment retry_count, assert reset_req for exactly REQ_CYCLES cycles, then go to HOLDOFF.
- HOLDOFF: reset_req=0. Wait for seq_done=0 (the sequencer has restarted), then go to WAIT_SEQ.
- FAILED:
  - failed=1, reset_req=0, link_ok=0.
  - clr_fail clears failed and retry_count, then goes to HOLDOFF.
  - clr_fail in any other state clears failed and retry_count only.
- soft_err_total: increments on every soft_err in any state, saturates at 16'hFFFF, and is cleared only by reset.
- last_cause: updates on entering REQ and holds until the next REQ.
- Reset mid-operation: reset_req deasserts asynchronously.
- seq_done dropping while in LINK_UP is treated as a link drop (cause 2).

Decomposition:
- Package aurora_mon_pkg:
  - state enum (WAIT_SEQ, WAIT_UP, LINK_UP, REQ, HOLDOFF, FAILED)
  - cause enum (CAUSE_NONE, CAUSE_TIMEOUT, CAUSE_DROP, CAUSE_SOFTERR)
- Sub-module aurora_err_window: soft-error window counter plus limit compare, producing a limit_hit pulse.

Test Plan (UP_TIMEOUT=50, REQ_CYCLES=4, WINDOW_CYCLES=20, SOFT_ERR_LIMIT=3, STABLE_CYCLES=30, MAX_RETRY=2):
- Normal bring-up: seq_done, then channel_up and lane_up=4'hF after 10 cycles -> link_ok=1, reset_req never asserted, retry_count=0.
- Timeout: seq_done with channel_up held 0 -> reset_req high for exactly 4 cycles starting 51 cycles after seq_done, last_cause=1, retry_count=1.
- Retries exhausted: timeouts repeated while seq_done toggles -> after 2 requests, failed=1 and no third reset_req. clr_fail -> failed=0, retry_count=0.
- Soft errors: 3 soft_err pulses within 20 cycles -> reset_req, last_cause=3. 3 pulses spread over 45 cycles -> no request. soft_err_total=6.
- Coincident events: hard_err and soft-error limit in the same cycle -> a single 4-cycle reset_req, last_cause=2.
- Asynchronous reset during REQ -> reset_req=0 immediately, state WAIT_SEQ, retry_count=0.

Source files
------------

// File: rtl/aurora_mon_pkg.sv
// Shared types and widths for the Aurora link monitor: FSM states and reset causes.
package aurora_mon_pkg;

  localparam int RETRY_W = 8;
  localparam int TOTAL_W = 16;

  typedef enum logic [2:0] {
    WAIT_SEQ = 3'd0,
    WAIT_UP  = 3'd1,
    LINK_UP  = 3'd2,
    REQ      = 3'd3,
    HOLDOFF  = 3'd4,
    FAILED   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_DROP    = 2'd2,
    CAUSE_SOFTERR = 2'd3
  } cause_t;

endpackage

// File: rtl/aurora_err_window.sv
// Soft-error observation window: counts soft errors per window and flags the
// cycle in which the count reaches the limit.
module aurora_err_window #(
  parameter int WINDOW_CYCLES  = 1000000,
  parameter int SOFT_ERR_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_soft_err,
  output logic o_limit_hit
);

  localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int CW = $clog2(SOFT_ERR_LIMIT + 1);

  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_count;
  logic          w_wrap;
  logic [CW-1:0] w_base;

  // An error in the wrap cycle belongs to the new window, so it builds on zero.
  assign w_wrap      = (r_timer == TW'(WINDOW_CYCLES - 1));
  assign w_base      = w_wrap ? '0 : r_count;
  assign o_limit_hit = i_active && i_soft_err && (w_base == CW'(SOFT_ERR_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_count <= '0;
    end else if (!i_active) begin
      r_timer <= '0;
      r_count <= '0;
    end else begin
      r_timer <= w_wrap ? '0 : r_timer + TW'(1);
      if (i_soft_err && (w_base != CW'(SOFT_ERR_LIMIT)))
        r_count <= w_base + CW'(1);
      else
        r_count <= w_base;
    end
  end

endmodule

// File: rtl/aurora_link_monitor.sv
// Aurora link supervisor: watches bring-up and link health, requests sequencer
// resets with a bounded retry budget and a sticky failure flag.
module aurora_link_monitor
  import aurora_mon_pkg::*;
#(
  parameter int NLANES         = 4,
  parameter int UP_TIMEOUT     = 100000000,
  parameter int REQ_CYCLES     = 100,
  parameter int WINDOW_CYCLES  = 1000000,
  parameter int SOFT_ERR_LIMIT = 16,
  parameter int STABLE_CYCLES  = 10000000,
  parameter int MAX_RETRY      = 8
) (
  input  logic                init_clk,
  input  logic                init_rst_n,
  input  logic                seq_done,
  input  logic                channel_up,
  input  logic [NLANES-1:0]   lane_up,
  input  logic                soft_err,
  input  logic                hard_err,
  input  logic                clr_fail,
  output logic                reset_req,
  output logic                link_ok,
  output logic                failed,
  output logic [RETRY_W-1:0]  retry_count,
  output logic [1:0]          last_cause,
  output logic [TOTAL_W-1:0]  soft_err_total
);

  localparam int UT_W = (UP_TIMEOUT > 1) ? $clog2(UP_TIMEOUT) : 1;
  localparam int RQ_W = $clog2(REQ_CYCLES + 1);
  localparam int ST_W = $clog2(STABLE_CYCLES + 1);

  state_t             r_state;
  cause_t             r_cause;
  logic [UT_W-1:0]    r_timer;
  logic [RQ_W-1:0]    r_req_cnt;
  logic [ST_W-1:0]    r_stable_cnt;
  logic               r_reset_req;
  logic               r_link_ok;
  logic               r_failed;
  logic [RETRY_W-1:0] r_retry;
  logic [TOTAL_W-1:0] r_total;

  logic w_link_good;
  logic w_drop;
  logic w_limit_hit;

  // Losing seq_done while up means the sequencer restarted under us: a drop.
  assign w_link_good = channel_up && (&lane_up);
  assign w_drop      = hard_err || !w_link_good || !seq_done;

  aurora_err_window #(
    .WINDOW_CYCLES  (WINDOW_CYCLES),
    .SOFT_ERR_LIMIT (SOFT_ERR_LIMIT)
  ) u_err_window (
    .clk         (init_clk),
    .rst_n       (init_rst_n),
    .i_active    (r_state == LINK_UP),
    .i_soft_err  (soft_err),
    .o_limit_hit (w_limit_hit)
  );

  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n) begin
      r_state      <= WAIT_SEQ;
      r_cause      <= CAUSE_NONE;
      r_timer      <= '0;
      r_req_cnt    <= '0;
      r_stable_cnt <= '0;
      r_reset_req  <= 1'b0;
      r_link_ok    <= 1'b0;
      r_failed     <= 1'b0;
      r_retry      <= '0;
      r_total      <= '0;
    end else begin
      r_link_ok <= (r_state == LINK_UP) && !w_drop && !w_limit_hit;

      if (soft_err && (r_total != '1))
        r_total <= r_total + TOTAL_W'(1);

      if (r_state != LINK_UP)
        r_stable_cnt <= '0;
      else if (r_stable_cnt != ST_W'(STABLE_CYCLES))
        r_stable_cnt <= r_stable_cnt + ST_W'(1);

      case (r_state)
        WAIT_SEQ: begin
          if (seq_done) begin
            r_state <= WAIT_UP;
            r_timer <= '0;
          end
        end
        WAIT_UP: begin
          if (!seq_done) begin
            r_state <= WAIT_SEQ;
          end else if (w_link_good) begin
            r_state <= LINK_UP;
          end else if (r_timer == UT_W'(UP_TIMEOUT - 1)) begin
            r_state   <= REQ;
            r_cause   <= CAUSE_TIMEOUT;
            r_req_cnt <= '0;
          end else begin
            r_timer <= r_timer + UT_W'(1);
          end
        end
        LINK_UP: begin
          if (w_drop || w_limit_hit) begin
            r_state   <= REQ;
            r_cause   <= w_drop ? CAUSE_DROP : CAUSE_SOFTERR;
            r_req_cnt <= '0;
          end else if (r_stable_cnt == ST_W'(STABLE_CYCLES - 1)) begin
            r_retry <= '0;
          end
        end
        REQ: begin
          // First REQ cycle decides between spending a retry and giving up.
          if (r_req_cnt == '0) begin
            if (r_retry >= RETRY_W'(MAX_RETRY)) begin
              r_state  <= FAILED;
              r_failed <= 1'b1;
            end else begin
              r_retry     <= r_retry + RETRY_W'(1);
              r_reset_req <= 1'b1;
              r_req_cnt   <= RQ_W'(1);
            end
          end else if (r_req_cnt == RQ_W'(REQ_CYCLES)) begin
            r_reset_req <= 1'b0;
            r_state     <= HOLDOFF;
          end else begin
            r_req_cnt <= r_req_cnt + RQ_W'(1);
          end
        end
        HOLDOFF: begin
          if (!seq_done)
            r_state <= WAIT_SEQ;
        end
        FAILED: begin
          if (clr_fail)
            r_state <= HOLDOFF;
        end
        default: r_state <= WAIT_SEQ;
      endcase

      // NOTE: placed after the case so this later non-blocking write wins over
      // any retry increment or failure set issued in the same cycle.
      if (clr_fail) begin
        r_failed <= 1'b0;
        r_retry  <= '0;
      end
    end
  end

  assign reset_req      = r_reset_req;
  assign link_ok        = r_link_ok;
  assign failed         = r_failed;
  assign retry_count    = r_retry;
  assign last_cause     = r_cause;
  assign soft_err_total = r_total;

endmodule

// File: tb/tb_aurora_link_monitor.sv
// Directed self-checking bench for aurora_link_monitor with shortened timing parameters.
module tb_aurora_link_monitor;

  logic        init_clk   = 1'b0;
  logic        init_rst_n = 1'b0;
  logic        seq_done   = 1'b0;
  logic        channel_up = 1'b0;
  logic [3:0]  lane_up    = 4'h0;
  logic        soft_err   = 1'b0;
  logic        hard_err   = 1'b0;
  logic        clr_fail   = 1'b0;
  logic        reset_req;
  logic        link_ok;
  logic        failed;
  logic [7:0]  retry_count;
  logic [1:0]  last_cause;
  logic [15:0] soft_err_total;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 init_clk = ~init_clk;

  aurora_link_monitor #(
    .NLANES         (4),
    .UP_TIMEOUT     (50),
    .REQ_CYCLES     (4),
    .WINDOW_CYCLES  (20),
    .SOFT_ERR_LIMIT (3),
    .STABLE_CYCLES  (30),
    .MAX_RETRY      (2)
  ) dut (
    .init_clk       (init_clk),
    .init_rst_n     (init_rst_n),
    .seq_done       (seq_done),
    .channel_up     (channel_up),
    .lane_up        (lane_up),
    .soft_err       (soft_err),
    .hard_err       (hard_err),
    .clr_fail       (clr_fail),
    .reset_req      (reset_req),
    .link_ok        (link_ok),
    .failed         (failed),
    .retry_count    (retry_count),
    .last_cause     (last_cause),
    .soft_err_total (soft_err_total)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    seq_done = 1'b0; channel_up = 1'b0; lane_up = 4'h0;
    soft_err = 1'b0; hard_err = 1'b0; clr_fail = 1'b0;
    @(negedge init_clk);
    init_rst_n = 1'b0;
    repeat (2) @(negedge init_clk);
    init_rst_n = 1'b1;
    @(negedge init_clk);
  endtask

  // Drive seq_done and a healthy link; returns in the first LINK_UP cycle.
  task automatic bring_up();
    seq_done = 1'b1; channel_up = 1'b1; lane_up = 4'hF;
    repeat (2) @(negedge init_clk);
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    seq_done = 1'b1; channel_up = 1'b1; lane_up = 4'hF; soft_err = 1'b1;
    init_rst_n = 1'b0;
    repeat (3) @(negedge init_clk);
    outs = {reset_req, link_ok, failed, retry_count, last_cause, soft_err_total};
    n_tests++;
    if (outs !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    seq_done = 1'b0; channel_up = 1'b0; lane_up = 4'h0; soft_err = 1'b0;
    init_rst_n = 1'b1;
    repeat (3) @(negedge init_clk);
    outs = {reset_req, link_ok, failed, retry_count, last_cause, soft_err_total};
    n_tests++;
    if (outs !== 30'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected 0", outs);
    end
  endtask

  task automatic test_bring_up();
    logic saw = 1'b0;
    apply_reset();
    seq_done = 1'b1;
    repeat (10) begin @(negedge init_clk); saw |= reset_req; end
    channel_up = 1'b1; lane_up = 4'hF;
    repeat (3) begin @(negedge init_clk); saw |= reset_req; end
    n_tests++;
    if (link_ok !== 1'b1) begin
      n_fail++; $display("FAIL bring_up_link_ok: got %b expected 1", link_ok);
    end
    n_tests++;
    if (saw !== 1'b0) begin
      n_fail++; $display("FAIL bring_up_no_req: got %b expected 0", saw);
    end
    n_tests++;
    if (retry_count !== 8'd0) begin
      n_fail++; $display("FAIL bring_up_retry: got %0d expected 0", retry_count);
    end
  endtask

  task automatic test_timeout();
    int first = -1;
    int n_hi = 0;
    apply_reset();
    seq_done = 1'b1;
    for (int k = 0; k < 62; k++) begin
      @(negedge init_clk);
      if (reset_req === 1'b1) begin
        if (first < 0) first = k;
        n_hi++;
      end
    end
    n_tests++;
    if (first !== 51) begin
      n_fail++; $display("FAIL timeout_start: got %0d expected 51", first);
    end
    n_tests++;
    if (n_hi !== 4) begin
      n_fail++; $display("FAIL timeout_len: got %0d expected 4", n_hi);
    end
    n_tests++;
    if (last_cause !== 2'd1) begin
      n_fail++; $display("FAIL timeout_cause: got %0d expected 1", last_cause);
    end
    n_tests++;
    if (retry_count !== 8'd1) begin
      n_fail++; $display("FAIL timeout_retry: got %0d expected 1", retry_count);
    end
  endtask

  task automatic test_retry_exhaust();
    int n_hi;
    int exp_hi;
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      n_hi = 0;
      exp_hi = (r < 2) ? 4 : 0;
      seq_done = 1'b1;
      repeat (62) begin @(negedge init_clk); if (reset_req === 1'b1) n_hi++; end
      n_tests++;
      if (n_hi !== exp_hi) begin
        n_fail++; $display("FAIL retry_round%0d_req: got %0d expected %0d", r, n_hi, exp_hi);
      end
      if (r < 2) begin
        seq_done = 1'b0;
        repeat (3) @(negedge init_clk);
      end
    end
    n_tests++;
    if (failed !== 1'b1) begin
      n_fail++; $display("FAIL exhaust_failed: got %b expected 1", failed);
    end
    n_tests++;
    if (retry_count !== 8'd2) begin
      n_fail++; $display("FAIL exhaust_retry: got %0d expected 2", retry_count);
    end
    clr_fail = 1'b1;
    @(negedge init_clk);
    clr_fail = 1'b0;
    n_tests++;
    if ({failed, retry_count} !== 9'd0) begin
      n_fail++; $display("FAIL clr_fail: got failed=%b retry=%0d expected 0/0", failed, retry_count);
    end
  endtask

  task automatic test_soft_err();
    logic saw = 1'b0;
    int n_hi = 0;
    apply_reset();
    bring_up();
    // Window phase t: 5/25/45 spread out; 58 then 59 (wrap) splits windows; 61,62 hit the limit.
    for (int t = 0; t <= 62; t++) begin
      soft_err = (t == 5) || (t == 25) || (t == 45) || (t == 58) ||
                 (t == 59) || (t == 61) || (t == 62);
      @(negedge init_clk);
      saw |= reset_req;
    end
    soft_err = 1'b0;
    n_tests++;
    if (saw !== 1'b0) begin
      n_fail++; $display("FAIL soft_no_early_req: got %b expected 0", saw);
    end
    repeat (12) begin @(negedge init_clk); if (reset_req === 1'b1) n_hi++; end
    n_tests++;
    if (n_hi !== 4) begin
      n_fail++; $display("FAIL soft_limit_req: got %0d expected 4", n_hi);
    end
    n_tests++;
    if (last_cause !== 2'd3) begin
      n_fail++; $display("FAIL soft_cause: got %0d expected 3", last_cause);
    end
    n_tests++;
    if (soft_err_total !== 16'd7) begin
      n_fail++; $display("FAIL soft_total: got %0d expected 7", soft_err_total);
    end
  endtask

  task automatic test_coincident();
    int n_hi = 0;
    apply_reset();
    bring_up();
    for (int t = 0; t <= 4; t++) begin
      soft_err = (t >= 2);
      hard_err = (t == 4);
      @(negedge init_clk);
    end
    soft_err = 1'b0; hard_err = 1'b0;
    repeat (12) begin @(negedge init_clk); if (reset_req === 1'b1) n_hi++; end
    n_tests++;
    if (n_hi !== 4) begin
      n_fail++; $display("FAIL coincident_req: got %0d expected 4", n_hi);
    end
    n_tests++;
    if (last_cause !== 2'd2) begin
      n_fail++; $display("FAIL coincident_cause: got %0d expected 2", last_cause);
    end
    n_tests++;
    if (retry_count !== 8'd1) begin
      n_fail++; $display("FAIL coincident_retry: got %0d expected 1", retry_count);
    end
  endtask

  task automatic test_stable();
    apply_reset();
    bring_up();
    repeat (5) @(negedge init_clk);
    lane_up = 4'b1011;
    repeat (10) @(negedge init_clk);
    n_tests++;
    if ({link_ok, last_cause, retry_count} !== {1'b0, 2'd2, 8'd1}) begin
      n_fail++;
      $display("FAIL lane_drop: got ok=%b cause=%0d retry=%0d expected 0/2/1",
               link_ok, last_cause, retry_count);
    end
    lane_up = 4'hF; seq_done = 1'b0;
    repeat (2) @(negedge init_clk);
    seq_done = 1'b1;
    repeat (5) @(negedge init_clk);
    n_tests++;
    if ({link_ok, retry_count} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL stable_early: got ok=%b retry=%0d expected 1/1", link_ok, retry_count);
    end
    repeat (35) @(negedge init_clk);
    n_tests++;
    if (retry_count !== 8'd0) begin
      n_fail++; $display("FAIL stable_clear: got %0d expected 0", retry_count);
    end
  endtask

  task automatic test_async_reset();
    logic found = 1'b0;
    logic [2:0] ok_seq;
    apply_reset();
    seq_done = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge init_clk);
      if (reset_req === 1'b1) begin found = 1'b1; break; end
    end
    n_tests++;
    if (found !== 1'b1) begin
      n_fail++; $display("FAIL async_req_seen: got %b expected 1", found);
    end
    #1 init_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({reset_req, retry_count, last_cause} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b retry=%0d cause=%0d expected 0/0/0",
               reset_req, retry_count, last_cause);
    end
    @(negedge init_clk);
    init_rst_n = 1'b1;
    channel_up = 1'b1; lane_up = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge init_clk);
      ok_seq[k] = link_ok;
    end
    n_tests++;
    if (ok_seq !== 3'b100) begin
      n_fail++; $display("FAIL async_restart_state: got %b expected 100", ok_seq);
    end
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_timeout();
    test_retry_exhaust();
    test_soft_err();
    test_coincident();
    test_stable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
